mp_addsub: RTL and testbench

Multi-precision adder/subtractor for the crypto datapath. It adds or subtracts two NWORDS×WORD_W-bit operands that arrive one word per transfer, least-significant word first. The carry or borrow ripples between words in an internal register. It generalises the single-bit full adder to arbitrary width and length, adds a subtract mode, and uses valid/ready handshakes on both sides. It sits between the operand buffers and the modular-reduction stage.

---
 rtl/mp_arith_pkg.sv | 18 +
 rtl/mp_word_add.sv | 18 +
 rtl/mp_addsub.sv | 117 +++++++++++
 tb/tb_mp_addsub.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mp_arith_pkg.sv
// Shared constants for the multi-precision arithmetic datapath.
package mp_arith_pkg;

    // Operation encoding carried on in_sub
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Default operand geometry, shared with the reduction stage
    localparam int WORD_W_DEF = 32;
    localparam int NWORDS_DEF = 8;

    // Operation sequencing: IDLE waits for word 0, RUN covers words 1..NWORDS-1
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mp_state_t;

endpackage

// File: rtl/mp_word_add.sv
// Combinational WORD_W-bit adder with carry-in and carry-out.
module mp_word_add #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_cin,
    output logic [WORD_W-1:0] o_sum,
    output logic              o_cout
);

    logic [WORD_W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{WORD_W{1'b0}}, i_cin};
    assign o_sum  = w_full[WORD_W-1:0];
    assign o_cout = w_full[WORD_W];

endmodule

// File: rtl/mp_addsub.sv
// Word-serial multi-precision add/subtract, LSW first, one output register stage.
module mp_addsub
    import mp_arith_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int NWORDS = NWORDS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              out_carry
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    mp_state_t         r_state;
    mp_state_t         w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_carry;
    logic              r_mode;
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_out_carry;

    logic              w_in_xfer;
    logic              w_first;
    logic              w_last;
    logic              w_mode;
    logic              w_cin;
    logic [WORD_W-1:0] w_b_eff;
    logic [WORD_W-1:0] w_sum;
    logic              w_cout;

    // Single register stage: accept whenever the slot is empty or draining
    assign in_ready  = !r_out_valid || out_ready;
    assign w_in_xfer = in_valid && in_ready;

    // Word 0 takes its mode and carry-in (1 for two's-complement subtract) from in_sub
    assign w_first = (r_state == ST_IDLE);
    assign w_last  = (r_idx == LAST_IDX);
    assign w_mode  = w_first ? in_sub : r_mode;
    assign w_cin   = w_first ? in_sub : r_carry;
    assign w_b_eff = (w_mode == OP_SUB) ? ~in_b : in_b;

    mp_word_add #(.WORD_W(WORD_W)) u_add (
        .i_a    (in_a),
        .i_b    (w_b_eff),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: leave IDLE on word 0 (unless single-word), return after the last word
    always_comb begin
        w_state_nxt = r_state;
        if (w_in_xfer) begin
            case (r_state)
                ST_IDLE: if (NWORDS > 1) w_state_nxt = ST_RUN;
                ST_RUN:  if (w_last)     w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Word index, inter-word carry and latched mode advance only on accepted words
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_mode  <= OP_ADD;
        end else if (w_in_xfer) begin
            r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
            r_carry <= w_cout;
            if (w_first) r_mode <= in_sub;
        end
    end

    // Output register: load on accept, drop valid when drained with nothing new
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_carry <= 1'b0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sum;
            r_out_last  <= w_last;
            // Subtract reports borrow, which is the inverted carry-out
            r_out_carry <= w_last ? (w_cout ^ (w_mode == OP_SUB)) : 1'b0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_carry = r_out_carry;

endmodule

// File: tb/tb_mp_addsub.sv
// Bench for mp_addsub (WORD_W=8, NWORDS=4): operand-level model plus directed literals.
module tb_mp_addsub;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_carry;

    logic         dir_ready;
    logic         rand_en;
    logic         rand_ready;

    int checks   = 0;
    int failures = 0;

    assign out_ready = rand_en ? rand_ready : dir_ready;

    always #5 clk = ~clk;

    mp_addsub #(.WORD_W(W), .NWORDS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_carry (out_carry)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Randomised downstream readiness
    always @(posedge clk) begin
        #1 rand_ready = ($urandom_range(0, 3) != 0);
    end

    // Behavioural model: operands accumulate per operation; each result word is the
    // corresponding word of the plain (A+B) or (A-B) over the words seen so far.
    logic        m_ok = 1'b0;
    logic        m_valid, m_last, m_carry, m_zero;
    logic [W-1:0] m_data;
    logic        m_mode;
    int          m_idx;
    logic [32:0] m_a, m_b, m_s;

    always @(negedge clk) begin
        if (m_ok) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            if (m_valid || m_zero) begin
                chk("out_data", 32'(out_data), 32'(m_data));
                chk("out_last", 32'(out_last), 32'(m_last));
                chk("out_carry", 32'(out_carry), 32'(m_carry));
            end
        end
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_last = 0; m_carry = 0;
            m_idx = 0; m_mode = 0; m_zero = 1; m_ok = 1;
            m_a = 0; m_b = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            if (m_idx == 0) begin
                m_mode = in_sub; m_a = 0; m_b = 0;
            end
            m_a[8*m_idx +: 8] = in_a;
            m_b[8*m_idx +: 8] = in_b;
            m_s = m_mode ? (m_a - m_b) : (m_a + m_b);
            m_data  = m_s[8*m_idx +: 8];
            m_last  = (m_idx == N - 1);
            m_carry = m_last ? (m_mode ? (m_a < m_b) : m_s[32]) : 1'b0;
            m_valid = 1; m_zero = 0;
            m_idx   = (m_idx + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    end

    // Capture of output transfers for the literal expectations
    logic [9:0] cap_q[$];
    always @(negedge clk) begin
        if (!rst_n) cap_q.delete();
        else if (out_valid && out_ready) cap_q.push_back({out_carry, out_last, out_data});
    end

    // Drive one word; returns at posedge+1 after it is accepted
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        in_valid = 1; in_a = a; in_b = b; in_sub = s;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send_timeout", 32'(1), 32'(0));
        in_valid = 0;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] subs);
        for (int i = 0; i < N; i++) send(a[8*i +: 8], b[8*i +: 8], subs[i]);
    endtask

    task automatic expect_op(input string nm, input logic [31:0] res, input logic c);
        logic [9:0] e;
        int t;
        t = 0;
        while (cap_q.size() < N && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (cap_q.size() < N) begin
            chk({nm, "_timeout"}, 32'(cap_q.size()), 32'(N));
            return;
        end
        for (int i = 0; i < N; i++) begin
            e = cap_q.pop_front();
            chk({nm, "_data"}, 32'(e[7:0]), 32'(res[8*i +: 8]));
            chk({nm, "_last"}, 32'(e[8]), 32'(i == N - 1));
            if (i == N - 1) chk({nm, "_carry"}, 32'(e[9]), 32'(c));
        end
    endtask

    initial begin
        int t0;
        rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_sub = 0;
        dir_ready = 1; rand_en = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_last", 32'(out_last), 32'(0));
        chk("rst_out_carry", 32'(out_carry), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));

        // Words are LSW first: value = {w3,w2,w1,w0}
        do_op(32'h00000001, 32'hFFFFFFFF, 4'b0000);
        expect_op("add_wrap", 32'h00000000, 1'b1);
        do_op(32'h12345678, 32'h11111111, 4'b0000);
        expect_op("add_nocarry", 32'h23456789, 1'b0);
        do_op(32'h00000000, 32'h00000001, 4'b1111);
        expect_op("sub_borrow", 32'hFFFFFFFF, 1'b1);
        do_op(32'h00000005, 32'h00000003, 4'b1111);
        expect_op("sub_noborrow", 32'h00000002, 1'b0);
        // Mode taken from word 0 only
        do_op(32'h00000000, 32'h00000001, 4'b0101);
        expect_op("mode_latch_sub", 32'hFFFFFFFF, 1'b1);
        do_op(32'h00000001, 32'hFFFFFFFF, 4'b1110);
        expect_op("mode_latch_add", 32'h00000000, 1'b1);

        // Backpressure mid-operation
        send(8'h78, 8'h11, 1'b0);
        send(8'h56, 8'h11, 1'b0);
        dir_ready = 0;
        in_valid = 1; in_a = 8'h34; in_b = 8'h11; in_sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'(0));
            chk("bp_out_data", 32'(out_data), 32'h67);
            @(posedge clk); #1;
        end
        dir_ready = 1;
        send(8'h34, 8'h11, 1'b0);
        send(8'h12, 8'h11, 1'b0);
        expect_op("bp", 32'h23456789, 1'b0);

        // Back-to-back operations at one word per cycle
        t0 = $time;
        do_op(32'hFFFFFFFF, 32'h00000001, 4'b0000);
        do_op(32'h80000000, 32'h80000001, 4'b1111);
        chk("stream_cycles", 32'(($time - t0) / 10), 32'(2 * N));
        expect_op("b2b_add", 32'h00000000, 1'b1);
        expect_op("b2b_sub", 32'hFFFFFFFF, 1'b1);

        // Reset after two words; the next word is a fresh word 0
        send(8'hFF, 8'h01, 1'b0);
        send(8'hFF, 8'h00, 1'b0);
        rst_n = 0;
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_data", 32'(out_data), 32'(0));
        chk("mid_rst_last", 32'(out_last), 32'(0));
        chk("mid_rst_carry", 32'(out_carry), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
        rst_n = 1;
        do_op(32'h00000005, 32'h00000003, 4'b0001);
        expect_op("post_rst_sub", 32'h00000002, 1'b0);

        // Random traffic under random backpressure, checked by the model
        rand_en = 1;
        for (int op = 0; op < 60; op++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                send(W'($urandom), W'($urandom), 1'($urandom));
            end
        end
        rand_en = 0;
        repeat (4) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
